// File: rtl/serial_pkg.sv
// Shared definitions for the serializer: FSM state encoding, default word width
// and the even-parity helper used when the parity bit is compiled in.
package serial_pkg;

    // Serializer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // Default frame word width; must match the deserializer
    localparam int DATA_W_DEFAULT = 8;

    // Widest word the parity helper accepts; callers zero-extend narrower words,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_W_MAX = 64;

    // Even parity bit: XOR of all word bits, so word plus parity has an even count of ones
    function automatic logic parity_even(input logic [PARITY_W_MAX-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serializador.sv
// serializador: parallel-to-serial front end feeding the deserializer.
// Accepts words on a valid/ready handshake into a one-entry holding buffer and
// shifts them out MSB first on data_out with write_out marking frame bits.
// A new frame only starts from IDLE while link_busy_in is low; every frame is
// followed by GAP_CYCLES idle cycles.
// Build option: define SERIALIZADOR_PARITY_EN to append an even-parity bit to
// each frame (frame becomes DATA_W+1 bits long).
module serializador
    import serial_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk_100KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid_in,
    output logic              byte_ready_out,
    input  logic              link_busy_in,
    output logic              data_out,
    output logic              write_out,
    output logic              busy_out,
    output logic [CNT_W-1:0]  frames_sent_out
);

    // Number of bits on the wire per frame
`ifdef SERIALIZADOR_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif

    localparam int                   BIT_CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [3:0]           GAP_LAST  = 4'(GAP_CYCLES - 1);

    // Holding buffer
    logic [DATA_W-1:0]    buf_q;
    logic                 full_q;
    logic                 full_d;
    logic                 ready_q;

    // Shifter / FSM
    ser_state_t           state_q;
    logic [DATA_W-1:0]    shift_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [3:0]           gap_cnt_q;
    logic                 data_q;
    logic                 write_q;
    logic [CNT_W-1:0]     frames_q;
`ifdef SERIALIZADOR_PARITY_EN
    logic                 parity_q;
`endif

    logic                 accept;
    logic                 load_now;

    // Producer handshake: ready is a register, so no path from byte_valid_in
    assign accept   = byte_valid_in && ready_q;

    // Shifter load: only from IDLE, with a word waiting and the link free
    assign load_now = (state_q == IDLE) && full_q && !link_busy_in;

    // Next buffer occupancy; load and accept never coincide since ready is low while full
    always_comb begin
        full_d = full_q;
        if (load_now) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
        end
    end

    // Holding buffer register, full flag and registered ready
    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            buf_q   <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            full_q  <= full_d;
            ready_q <= !full_d;
            if (accept) begin
                buf_q <= byte_in;
            end
        end
    end

    // Frame FSM: load, shift out MSB first, then hold the line idle for the gap
    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= 1'b0;
            write_q   <= 1'b0;
            frames_q  <= '0;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    data_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (load_now) begin
                        shift_q   <= buf_q;
                        bit_cnt_q <= '0;
`ifdef SERIALIZADOR_PARITY_EN
                        parity_q  <= parity_even(PARITY_W_MAX'(buf_q));
`endif
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    write_q <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
                    // Word bits first, parity as the trailing bit
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W)) begin
                        data_q <= parity_q;
                    end else begin
                        data_q <= shift_q[DATA_W-1];
                    end
`else
                    data_q  <= shift_q[DATA_W-1];
`endif
                    shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    // Frame counted on its last bit; link_busy_in is ignored mid-frame
                    if (bit_cnt_q == LAST_BIT) begin
                        frames_q  <= frames_q + 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end

                GAP: begin
                    data_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    data_q  <= 1'b0;
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready_out  = ready_q;
    assign data_out        = data_q;
    assign write_out       = write_q;
    assign busy_out        = (state_q != IDLE) || full_q;
    assign frames_sent_out = frames_q;

endmodule

// File: doc/serializador.md
Name: serializador

Overview:
- Upstream stage of the deserializer: takes parallel bytes from a producer via valid/ready and emits them as a bit-serial stream on data_out/write_out.
- Its outputs drive the deserializer's data_in/write_in directly.
- Flow control honours the deserializer's status_out, wired to link_busy_in.
- Includes a one-entry holding buffer so the producer can hand over the next byte while the current one shifts.

Parameters:
- DATA_W, 8, word width in bits; must equal the deserializer word width.
- GAP_CYCLES, 2, minimum idle cycles (write_out low) between consecutive frames; legal range 1..15.
- CNT_W, 16, width of the sent-frame counter.

Ports:
- clk_100KHz  input  1  single clock, same domain as deserializer.
- reset  input  1  asynchronous, active-low reset.
- byte_in  input  DATA_W  parallel word from producer.
- byte_valid_in  input  1  byte_in valid.
- byte_ready_out  output  1  holding buffer empty; transfer when valid&&ready at clock edge.
- link_busy_in  input  1  deserializer busy (its status_out); no new frame may start while high.
- data_out  output  1  serial bit.
- write_out  output  1  high exactly while data_out carries a frame bit.
- busy_out  output  1  high whenever the FSM is not in IDLE or the buffer is full.
- frames_sent_out  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0, async) values:
  - data_out=0, write_out=0, busy_out=0, frames_sent_out=0, byte_ready_out=1.
  - Buffer empty; FSM in IDLE.
- Buffer: one register plus full flag.
  - Written on valid&&ready; byte_ready_out = !full, registered from the flag with no combinational path from byte_valid_in.
  - Emptied when the FSM loads the shifter.
  - Load and a new write in the same cycle is illegal because ready is low while full.
  - The buffer refills earliest the cycle after the load.
- FSM states IDLE, SHIFT, GAP:
  - IDLE -> SHIFT when full && !link_busy_in. The load cycle copies the buffer into the shift register, clears full, and sets bit_cnt=0.
  - SHIFT: each cycle drives write_out=1 and data_out=shift[DATA_W-1] (MSB first), then shifts left and increments bit_cnt.
  - SHIFT lasts exactly DATA_W cycles. After the last bit: frames_sent_out += 1, then go to GAP.
  - GAP: write_out=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
- link_busy_in is sampled only in IDLE. Once SHIFT starts, the frame completes regardless of link_busy_in.
- Latency: byte accepted at edge N, idle FSM, link free -> first bit visible after edge N+2; write_out high for edges N+2..N+DATA_W+1.
- Back-to-back throughput: one frame per DATA_W+GAP_CYCLES+1 cycles (the +1 is the IDLE load cycle).
- Reset asserted mid-frame: frame is aborted immediately, write_out drops asynchronously, the buffered byte is discarded, and the counter clears.

Optional Feature:
- SERIALIZADOR_PARITY_EN defined:
  - SHIFT lasts DATA_W+1 cycles; the extra final bit is the even parity (XOR) of the frame word, with write_out high.
  - Throughput and latency figures grow by 1.
- Undefined: no parity bit, plain DATA_W-bit frames. The deserializer must be built to match.

Decomposition:
- Shared package serial_pkg:
  - ser_state_t enum {IDLE, SHIFT, GAP}.
  - Localparam DATA_W_DEFAULT=8.
  - Function parity_even().
- No sub-module; buffer, FSM and counter stay flat in one module.

Test Plan:
- Reset then byte_in=8'hA5 valid one cycle, link free -> data_out sequence 1,0,1,0,0,1,0,1 with write_out high 8 cycles; frames_sent_out=1.
- link_busy_in=1 held, byte 8'h3C accepted -> write_out stays 0 and byte_ready_out=0. Release busy -> frame 0,0,1,1,1,1,0,0 starts 1 cycle later.
- Continuous valid stream 8'h01,8'h02,8'h03 -> three frames, each separated by exactly GAP_CYCLES+1 idle cycles; second byte accepted during first frame; counter=3.
- Raise link_busy_in mid-frame -> current frame completes all 8 bits; next frame waits for busy low.
- Assert reset at bit 4 of 8'hFF -> write_out=0 immediately, byte_ready_out=1, counter=0; after release no residual frame emitted.
- With SERIALIZADOR_PARITY_EN, send 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity 1).
